triple_max_stream: RTL and testbench
====================================

TRIPLE_MAX_STREAM -- requirements
Module: triple_max_stream

Interface
REQ-001 The block SHALL have these ports: clk  input  1  sole clock, all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 clear  input  1  synchronous flush of the partial triple and the pending result.
REQ-004 in_valid  input  1  in_data holds a valid sample.
REQ-005 in_data  input  3  unsigned sample; samples arrive in order a, b, c.
REQ-006 in_ready  output  1  block can accept a sample this cycle.
REQ-007 out_valid  output  1  out_onehot and out_max hold a valid result.
REQ-008 out_onehot  output  3  winner: 100=a, 010=b, 001=c.
REQ-009 out_max  output  3  maximum value of the triple.
REQ-010 out_ready  input  1  consumer accepts the result this cycle.
REQ-011 wins_a, wins_b, wins_c  output  8 each  per-channel win counters; present only with WIN_COUNT_EN.

Function
REQ-012 The block SHALL implement the states S_A, S_B, S_C and S_OUT.
REQ-013 A sample SHALL be accepted on any clock edge where in_valid=1 and in_ready=1.
REQ-014 in_ready SHALL be 1 in S_A, S_B and S_C, and SHALL be 0 in S_OUT.
REQ-015 Transitions SHALL be:
- S_A -> S_B on accept, sample registered as a;
- S_B -> S_C on accept, sample registered as b;
- S_C -> S_OUT on accept, sample registered as c;
- S_OUT -> S_A on out_valid & out_ready.
REQ-016 When no handshake occurs, the state SHALL NOT change.
REQ-017 The comparison SHALL use unsigned 3-bit values.
REQ-018 out_max SHALL equal max(a,b,c).
REQ-019 out_onehot SHALL be exactly one-hot, with ties resolved a > b > c:
- a wins if a>=b and a>=c;
- else b wins if b>=c;
- else c wins.
REQ-020 The result SHALL be registered, with out_valid=1 on the first cycle after c is accepted (latency 1 cycle from the third accept).
REQ-021 out_valid SHALL be 1 only in S_OUT.
REQ-022 out_onehot and out_max SHALL be held stable while out_valid=1 and out_ready=0.
REQ-023 A new sample SHALL be accepted no earlier than the cycle after the result handshake.
REQ-024 When out_valid=0, out_onehot and out_max SHALL be 3'b000.
REQ-025 clear=1 SHALL force the state to S_A and out_valid to 0 on the next edge, discarding partial samples.
REQ-026 clear SHALL take priority over any simultaneous input or output handshake.
REQ-027 A sample presented together with clear=1 SHALL be dropped, even though in_ready may be 1.
REQ-028 in_valid asserted while in_ready=0 SHALL have no effect; the upstream SHALL hold the sample.

Reset
REQ-029 Asserting rst_n=0 SHALL immediately reset the block, without waiting for a clock edge, to: state S_A, a/b/c registers 0, out_valid 0, out_onehot 000, out_max 000, and all win counters 0.
REQ-030 With rst_n=0, in_ready SHALL be 0.
REQ-031 in_ready SHALL become 1 on the first clk edge after rst_n deasserts.
REQ-032 Reset asserted mid-triple or with a pending result SHALL discard all data, and no partial result SHALL appear after release.

Configuration
REQ-033 The macro TRIPLE_MAX_WIN_COUNT_EN SHALL compile in the ports wins_a, wins_b and wins_c.
REQ-034 With the macro, on each result handshake, the counter of the winning channel SHALL increment by 1, saturating at 255.
REQ-035 With the macro, clear SHALL zero all counters.
REQ-036 Without the macro, the counter ports and logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-037 Basic: samples 3,6,1 with out_ready=1 -> 1 cycle after the third accept, out_valid=1, out_onehot=010, out_max=6; next cycle back to S_A with in_ready=1.
REQ-038 Ties: triples 5,5,2 -> 100/5; 1,7,7 -> 010/7; 0,0,0 -> 100/0; 2,3,4 -> 001/4.
REQ-039 Backpressure: samples 7,0,0 with out_ready=0 for 5 cycles -> out_valid and 100/7 held stable and in_ready=0 throughout; handshake on out_ready=1, then in_ready=1 the next cycle.
REQ-040 Clear/reset: accept 4,2, then clear=1 together with in_valid -> state S_A and the sample dropped; then 1,1,3 -> 001/3. Repeat with rst_n pulsed low between edges -> outputs zero immediately.
REQ-041 With TRIPLE_MAX_WIN_COUNT_EN: 300 triples each won by a -> wins_a saturates at 255, wins_b and wins_c stay 0; clear -> all counters 0.

Source files
------------

// File: rtl/triple_max_stream.sv
// Collects three 3-bit samples (a, b, c) and reports the maximum plus a one-hot winner, ties going a > b > c.
// Optional per-channel saturating win counters are compiled in with the macro TRIPLE_MAX_WIN_COUNT_EN.
module triple_max_stream (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clear,
   input  logic       in_valid,
   input  logic [2:0] in_data,
   output logic       in_ready,
   output logic       out_valid,
   output logic [2:0] out_onehot,
   output logic [2:0] out_max,
   input  logic       out_ready
`ifdef TRIPLE_MAX_WIN_COUNT_EN
   ,
   output logic [7:0] wins_a,
   output logic [7:0] wins_b,
   output logic [7:0] wins_c
`endif
);

   typedef enum logic [1:0] {S_A, S_B, S_C, S_OUT} state_t;

   state_t     state_q, state_d;
   logic       ready_q, ready_d;
   logic [2:0] a_q, a_d;
   logic [2:0] b_q, b_d;
   logic [2:0] onehot_q, onehot_d;
   logic [2:0] max_q, max_d;
   logic       accept;
   logic       out_fire;
   logic [2:0] win_onehot;
   logic [2:0] win_max;

   // in_ready stays low until the first edge after reset release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_A;
         ready_q  <= 1'b0;
         a_q      <= 3'd0;
         b_q      <= 3'd0;
         onehot_q <= 3'd0;
         max_q    <= 3'd0;
      end else begin
         state_q  <= state_d;
         ready_q  <= ready_d;
         a_q      <= a_d;
         b_q      <= b_d;
         onehot_q <= onehot_d;
         max_q    <= max_d;
      end
   end

   always_comb begin
      accept   = in_valid & in_ready & ~clear;
      out_fire = out_valid & out_ready & ~clear;
      ready_d  = 1'b1;
      state_d  = state_q;
      if (clear) begin
         state_d = S_A;
      end else begin
         case (state_q)
            S_A:     if (accept)   state_d = S_B;
            S_B:     if (accept)   state_d = S_C;
            S_C:     if (accept)   state_d = S_OUT;
            S_OUT:   if (out_fire) state_d = S_A;
            default: state_d = S_A;
         endcase
      end
   end

   always_comb begin
      in_ready   = ready_q & (state_q != S_OUT);
      out_valid  = (state_q == S_OUT);
      out_onehot = onehot_q;
      out_max    = max_q;
   end

   // The incoming sample is c, so the winner is resolved straight from the input bus
   always_comb begin
      win_onehot = 3'b001;
      win_max    = in_data;
      if ((a_q >= b_q) && (a_q >= in_data)) begin
         win_onehot = 3'b100;
         win_max    = a_q;
      end else if (b_q >= in_data) begin
         win_onehot = 3'b010;
         win_max    = b_q;
      end
   end

   // Result registers are zeroed whenever no result is pending
   always_comb begin
      a_d      = a_q;
      b_d      = b_q;
      onehot_d = onehot_q;
      max_d    = max_q;
      if (clear) begin
         a_d      = 3'd0;
         b_d      = 3'd0;
         onehot_d = 3'd0;
         max_d    = 3'd0;
      end else begin
         if (accept && state_q == S_A) a_d = in_data;
         if (accept && state_q == S_B) b_d = in_data;
         if (accept && state_q == S_C) begin
            onehot_d = win_onehot;
            max_d    = win_max;
         end
         if (out_fire) begin
            onehot_d = 3'd0;
            max_d    = 3'd0;
         end
      end
   end

`ifdef TRIPLE_MAX_WIN_COUNT_EN
   logic [7:0] wins_a_q, wins_a_d;
   logic [7:0] wins_b_q, wins_b_d;
   logic [7:0] wins_c_q, wins_c_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wins_a_q <= 8'd0;
         wins_b_q <= 8'd0;
         wins_c_q <= 8'd0;
      end else begin
         wins_a_q <= wins_a_d;
         wins_b_q <= wins_b_d;
         wins_c_q <= wins_c_d;
      end
   end

   // Counters saturate at 255 rather than wrapping
   always_comb begin
      wins_a_d = wins_a_q;
      wins_b_d = wins_b_q;
      wins_c_d = wins_c_q;
      if (clear) begin
         wins_a_d = 8'd0;
         wins_b_d = 8'd0;
         wins_c_d = 8'd0;
      end else if (out_fire) begin
         if (onehot_q[2] && wins_a_q != 8'hFF) wins_a_d = wins_a_q + 8'd1;
         if (onehot_q[1] && wins_b_q != 8'hFF) wins_b_d = wins_b_q + 8'd1;
         if (onehot_q[0] && wins_c_q != 8'hFF) wins_c_d = wins_c_q + 8'd1;
      end
   end

   assign wins_a = wins_a_q;
   assign wins_b = wins_b_q;
   assign wins_c = wins_c_q;
`endif

endmodule

// File: tb/tb_triple_max_stream.sv
// Directed self-checking bench for triple_max_stream; counter checks are built when TRIPLE_MAX_WIN_COUNT_EN is defined.
module tb_triple_max_stream;

   logic       clk;
   logic       rst_n;
   logic       clear;
   logic       in_valid;
   logic [2:0] in_data;
   logic       in_ready;
   logic       out_valid;
   logic [2:0] out_onehot;
   logic [2:0] out_max;
   logic       out_ready;
`ifdef TRIPLE_MAX_WIN_COUNT_EN
   logic [7:0] wins_a;
   logic [7:0] wins_b;
   logic [7:0] wins_c;
`endif

   int checkCount = 0;
   int errorCount = 0;

   triple_max_stream dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (clear),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_onehot (out_onehot),
      .out_max    (out_max),
      .out_ready  (out_ready)
`ifdef TRIPLE_MAX_WIN_COUNT_EN
      ,
      .wins_a     (wins_a),
      .wins_b     (wins_b),
      .wins_c     (wins_c)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Presents one sample and returns 1ns after the edge that accepted it
   task automatic applyStimulus(input logic [2:0] value);
      int waitCycles = 0;
      in_valid = 1'b1;
      in_data  = value;
      while (!in_ready && waitCycles < 20) begin
         @(posedge clk);
         #1;
         waitCycles++;
      end
      if (!in_ready) checkOutput("accept_timeout", 8'd0, 8'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic runTriple(input string tag, input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                            input logic [2:0] expOnehot, input logic [2:0] expMax);
      out_ready = 1'b1;
      applyStimulus(a);
      applyStimulus(b);
      applyStimulus(c);
      checkOutput({tag, "_valid"}, {7'd0, out_valid}, 8'd1);
      checkOutput({tag, "_onehot"}, {5'd0, out_onehot}, {5'd0, expOnehot});
      checkOutput({tag, "_max"}, {5'd0, out_max}, {5'd0, expMax});
      checkOutput({tag, "_ready_low"}, {7'd0, in_ready}, 8'd0);
      @(posedge clk);
      #1;
      checkOutput({tag, "_done_valid"}, {7'd0, out_valid}, 8'd0);
      checkOutput({tag, "_done_ready"}, {7'd0, in_ready}, 8'd1);
      checkOutput({tag, "_done_max"}, {5'd0, out_max}, 8'd0);
   endtask

   initial begin
      rst_n     = 1'b0;
      clear     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 3'd0;
      out_ready = 1'b0;

      #1;
      checkOutput("rst_in_ready", {7'd0, in_ready}, 8'd0);
      checkOutput("rst_out_valid", {7'd0, out_valid}, 8'd0);
      checkOutput("rst_onehot", {5'd0, out_onehot}, 8'd0);
      checkOutput("rst_max", {5'd0, out_max}, 8'd0);
`ifdef TRIPLE_MAX_WIN_COUNT_EN
      checkOutput("rst_wins_a", wins_a, 8'd0);
`endif
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("release_ready_before_edge", {7'd0, in_ready}, 8'd0);
      @(posedge clk);
      #1;
      checkOutput("release_ready_after_edge", {7'd0, in_ready}, 8'd1);

      $display("[TB] basic and tie vectors");
      runTriple("basic", 3'd3, 3'd6, 3'd1, 3'b010, 3'd6);
      runTriple("tie_ab", 3'd5, 3'd5, 3'd2, 3'b100, 3'd5);
      runTriple("tie_bc", 3'd1, 3'd7, 3'd7, 3'b010, 3'd7);
      runTriple("zeros", 3'd0, 3'd0, 3'd0, 3'b100, 3'd0);
      runTriple("rising", 3'd2, 3'd3, 3'd4, 3'b001, 3'd4);

      $display("[TB] backpressure");
      out_ready = 1'b0;
      applyStimulus(3'd7);
      applyStimulus(3'd0);
      applyStimulus(3'd0);
      in_valid = 1'b1;
      in_data  = 3'd5;
      for (int i = 0; i < 5; i++) begin
         checkOutput("bp_valid", {7'd0, out_valid}, 8'd1);
         checkOutput("bp_onehot", {5'd0, out_onehot}, 8'd4);
         checkOutput("bp_max", {5'd0, out_max}, 8'd7);
         checkOutput("bp_in_ready", {7'd0, in_ready}, 8'd0);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      checkOutput("bp_release_valid", {7'd0, out_valid}, 8'd0);
      checkOutput("bp_release_ready", {7'd0, in_ready}, 8'd1);
      runTriple("bp_after", 3'd2, 3'd3, 3'd4, 3'b001, 3'd4);

      $display("[TB] clear mid-triple");
      applyStimulus(3'd4);
      applyStimulus(3'd2);
      in_valid = 1'b1;
      in_data  = 3'd7;
      clear    = 1'b1;
      @(posedge clk);
      #1;
      clear    = 1'b0;
      in_valid = 1'b0;
      checkOutput("clr_valid", {7'd0, out_valid}, 8'd0);
      checkOutput("clr_ready", {7'd0, in_ready}, 8'd1);
      runTriple("clr_after", 3'd1, 3'd1, 3'd3, 3'b001, 3'd3);

      $display("[TB] clear with pending result");
      out_ready = 1'b0;
      applyStimulus(3'd6);
      applyStimulus(3'd1);
      applyStimulus(3'd2);
      out_ready = 1'b1;
      clear     = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      checkOutput("clr_pend_valid", {7'd0, out_valid}, 8'd0);
      checkOutput("clr_pend_onehot", {5'd0, out_onehot}, 8'd0);
      checkOutput("clr_pend_max", {5'd0, out_max}, 8'd0);

      $display("[TB] reset mid-triple");
      applyStimulus(3'd4);
      applyStimulus(3'd2);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("rst_mid_ready", {7'd0, in_ready}, 8'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("rst_mid_release_ready", {7'd0, in_ready}, 8'd1);
      runTriple("rst_mid_after", 3'd1, 3'd1, 3'd3, 3'b001, 3'd3);

      $display("[TB] reset with pending result");
      out_ready = 1'b0;
      applyStimulus(3'd5);
      applyStimulus(3'd3);
      applyStimulus(3'd6);
      checkOutput("rst_pend_before", {7'd0, out_valid}, 8'd1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("rst_pend_valid", {7'd0, out_valid}, 8'd0);
      checkOutput("rst_pend_onehot", {5'd0, out_onehot}, 8'd0);
      checkOutput("rst_pend_max", {5'd0, out_max}, 8'd0);
      checkOutput("rst_pend_ready", {7'd0, in_ready}, 8'd0);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("rst_pend_release_valid", {7'd0, out_valid}, 8'd0);
      runTriple("rst_pend_after", 3'd1, 3'd1, 3'd3, 3'b001, 3'd3);

`ifdef TRIPLE_MAX_WIN_COUNT_EN
      $display("[TB] win counters");
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      checkOutput("cnt_clear_a", wins_a, 8'd0);
      runTriple("cnt_b", 3'd1, 3'd6, 3'd2, 3'b010, 3'd6);
      checkOutput("cnt_b_one", wins_b, 8'd1);
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         applyStimulus(3'd7);
         applyStimulus(3'd0);
         applyStimulus(3'd0);
         @(posedge clk);
         #1;
      end
      checkOutput("cnt_sat_a", wins_a, 8'd255);
      checkOutput("cnt_sat_b", wins_b, 8'd0);
      checkOutput("cnt_sat_c", wins_c, 8'd0);
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      checkOutput("cnt_final_a", wins_a, 8'd0);
      checkOutput("cnt_final_b", wins_b, 8'd0);
      checkOutput("cnt_final_c", wins_c, 8'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
